// File: rtl/nps_outmem_if.sv
// ---------------------------------------------------------------------------
// nps_outmem_if : stream-capture and CPU read-port bundle for nps_outmem.
// master = stream source / CPU side, slave = the capture memory itself.
// ---------------------------------------------------------------------------
interface nps_outmem_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 5
);
    // Stream side
    logic                  set;
    logic                  vi;
    logic                  fi;
    logic [DATA_WIDTH-1:0] datai;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [ADR_WIDTH:0]    wcnt;
    // CPU side
    logic [ADR_WIDTH-1:0]  cpu_adr;
    logic                  cpu_rd;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic [DATA_WIDTH-1:0] chksum;

    modport master (
        output set, vi, fi, datai, cpu_adr, cpu_rd,
        input  busy, done, ovf, wcnt, cpu_rdata, chksum
    );

    modport slave (
        input  set, vi, fi, datai, cpu_adr, cpu_rd,
        output busy, done, ovf, wcnt, cpu_rdata, chksum
    );
endinterface

// File: rtl/nps_outmem.sv
// ---------------------------------------------------------------------------
// nps_outmem : stream-capture output memory at the tail of an NPS pipeline.
// Armed by set, stores each valid word at an incrementing address, closes the
// frame on the frame-end flag, and exposes the words through a registered
// CPU read port.
// Optional build macro NPS_OUTMEM_CHKSUM_EN adds a wrap-around frame checksum;
// without it chksum is tied to zero and no adder is built.
// ---------------------------------------------------------------------------
module nps_outmem #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_NUM   = 30,
    parameter int ADR_WIDTH  = 5
) (
    input  logic         clk,
    input  logic         reset_x,
    nps_outmem_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // Frame capacity expressed at counter width, so compares stay width-exact.
    localparam logic [ADR_WIDTH:0] LP_FULL = (ADR_WIDTH + 1)'(DATA_NUM);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADR_WIDTH:0]    r_wcnt;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DATA_NUM];

    logic                  w_active;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_adr_ok;

    // A valid word counts only while armed or capturing; set wins over it.
    assign w_active = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign w_accept = w_active && bus.vi && !bus.set;
    assign w_full   = (r_wcnt >= LP_FULL);
    assign w_wr     = w_accept && !w_full;
    assign w_drop   = w_accept && w_full;
    assign w_adr_ok = ({1'b0, bus.cpu_adr} < LP_FULL);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: set re-arms from anywhere; fi only counts with vi.
    // NOTE: the default assignment first guarantees every path drives
    // w_state_nxt, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.set) begin
            w_state_nxt = ST_ARMED;
        end else begin
            unique case (r_state)
                ST_IDLE:    w_state_nxt = ST_IDLE;
                ST_ARMED: begin
                    if (bus.vi) begin
                        w_state_nxt = bus.fi ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.vi && bus.fi) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE:    w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Word counter and sticky overflow flag; both cleared by set.
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            r_wcnt <= '0;
            r_ovf  <= 1'b0;
        end else if (bus.set) begin
            r_wcnt <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Capture write at the current count, on the same edge as the increment.
    // NOTE: the storage array has no reset so it maps onto plain RAM; its
    // contents are only meaningful once a frame has written them.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wcnt[ADR_WIDTH-1:0]] <= bus.datai;
        end
    end

    // Registered CPU read; out-of-range addresses return zero, data holds
    // between strobes, and a same-edge write is seen only on the next read.
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            r_rdata <= '0;
        end else if (bus.cpu_rd) begin
            r_rdata <= w_adr_ok ? r_mem[bus.cpu_adr] : '0;
        end
    end

`ifdef NPS_OUTMEM_CHKSUM_EN
    logic [DATA_WIDTH-1:0] r_chksum;

    // Wrap-around sum of stored words only; dropped words never reach it.
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            r_chksum <= '0;
        end else if (bus.set) begin
            r_chksum <= '0;
        end else if (w_wr) begin
            r_chksum <= r_chksum + bus.datai;
        end
    end

    assign bus.chksum = r_chksum;
`else
    assign bus.chksum = '0;
`endif

    assign bus.busy      = w_active;
    assign bus.done      = (r_state == ST_DONE);
    assign bus.ovf       = r_ovf;
    assign bus.wcnt      = r_wcnt;
    assign bus.cpu_rdata = r_rdata;

endmodule

// File: tb/tb_nps_outmem.sv
// ---------------------------------------------------------------------------
// tb_nps_outmem : self-checking bench for nps_outmem.
// A frame-level model (array + counters) predicts status after every edge;
// CPU read results go through a scoreboard queue popped by a monitor.
// Honours NPS_OUTMEM_CHKSUM_EN for the expected checksum.
// ---------------------------------------------------------------------------
module tb_nps_outmem;

    localparam int DW = 16;
    localparam int DN = 30;
    localparam int AW = 5;

    logic clk     = 1'b0;
    logic reset_x = 1'b1;

    always #5 clk = ~clk;

    nps_outmem_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus ();

    nps_outmem #(
        .DATA_WIDTH (DW),
        .DATA_NUM   (DN),
        .ADR_WIDTH  (AW)
    ) dut (
        .clk     (clk),
        .reset_x (reset_x),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [DW-1:0] m_mem [32];
    int            m_cnt  = 0;
    bit            m_open = 1'b0;   // frame is accepting words
    bit            m_ovf  = 1'b0;
    bit            m_done = 1'b0;   // a frame closed at the last edge
    logic [DW-1:0] m_sum  = '0;

    function automatic logic [DW-1:0] exp_chk();
`ifdef NPS_OUTMEM_CHKSUM_EN
        return m_sum;
`else
        return '0;
`endif
    endfunction

    // ---------------- read scoreboard ----------------
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] hold = '0;
    logic          rd_q = 1'b0;

    always @(posedge clk) rd_q <= reset_x ? 1'b0 : bus.cpu_rd;

    // Monitor: a read strobed at the last edge presents data now; otherwise
    // the previous read data must hold.
    always @(negedge clk) begin
        if (reset_x) begin
            hold = '0;
        end else begin
            if (rd_q) begin
                if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
                else hold = sb_q.pop_front();
            end
            check("cpu_rdata", bus.cpu_rdata, hold);
        end
    end

    // One clock of stimulus; model updated with the word's effect at this edge.
    task automatic cycle(input bit s, input bit v, input bit f, input logic [DW-1:0] d,
                         input bit rd = 1'b0, input logic [AW-1:0] a = '0);
        bus.set     = s;
        bus.vi      = v;
        bus.fi      = f;
        bus.datai   = d;
        bus.cpu_rd  = rd;
        bus.cpu_adr = a;
        if (rd) sb_q.push_back((int'(a) < DN) ? m_mem[a] : '0);
        m_done = 1'b0;
        if (s) begin
            m_open = 1'b1;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_sum  = '0;
        end else if (m_open && v) begin
            if (m_cnt < DN) begin
                m_mem[m_cnt] = d;
                m_cnt++;
                m_sum = m_sum + d;
            end else begin
                m_ovf = 1'b1;
            end
            if (f) begin
                m_open = 1'b0;
                m_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("busy",   bus.busy,   m_open);
        check("done",   bus.done,   m_done);
        check("wcnt",   bus.wcnt,   m_cnt);
        check("ovf",    bus.ovf,    m_ovf);
        check("chksum", bus.chksum, exp_chk());
    endtask

    task automatic read_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'(a));
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Reset raised between edges: outputs must clear without waiting for clk.
    task automatic async_reset();
        bus.set = 1'b0; bus.vi = 1'b0; bus.fi = 1'b0; bus.cpu_rd = 1'b0;
        @(posedge clk);
        #3 reset_x = 1'b1;
        #1;
        check("arst_busy",  bus.busy,      0);
        check("arst_done",  bus.done,      0);
        check("arst_ovf",   bus.ovf,       0);
        check("arst_wcnt",  bus.wcnt,      0);
        check("arst_rdata", bus.cpu_rdata, 0);
        check("arst_chk",   bus.chksum,    0);
        m_open = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_sum = '0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_x = 1'b0;
    endtask

    initial begin
        bus.set = 1'b0; bus.vi = 1'b0; bus.fi = 1'b0; bus.datai = '0;
        bus.cpu_rd = 1'b0; bus.cpu_adr = '0;
        repeat (3) @(posedge clk);
        #1 reset_x = 1'b0;
        check("rst_busy",  bus.busy,      0);
        check("rst_done",  bus.done,      0);
        check("rst_ovf",   bus.ovf,       0);
        check("rst_wcnt",  bus.wcnt,      0);
        check("rst_rdata", bus.cpu_rdata, 0);
        check("rst_chk",   bus.chksum,    0);

        // Continuous 30-word frame, data = index.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, i == 29, DW'(i));
        cycle(1'b0, 1'b0, 1'b0, '0);
`ifdef NPS_OUTMEM_CHKSUM_EN
        check("chksum_435", bus.chksum, 435);
`endif
        read_range(0, 31);

        // Same frame with idle gaps; fi raised on gap cycles must be ignored.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b1, i == 29, DW'(i));
            cycle(1'b0, 1'b0, 1'b1, DW'(i + 500));
        end
        read_range(0, 29);

        // Overflow: 32 words into a 30-word memory, fi on the last.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, i == 31, DW'(i));
        check("ovf_sticky", bus.ovf, 1);
        read_range(28, 31);

        // Mid-frame set aborts; second frame overwrites only addr 0..2.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        cycle(1'b1, 1'b1, 1'b0, 16'd999);   // set wins, word not stored
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, i == 2, DW'(100 + i));
        read_range(0, 9);

        // Words while idle are ignored; then a single-word frame.
        cycle(1'b0, 1'b1, 1'b1, 16'd55);
        cycle(1'b0, 1'b1, 1'b1, 16'd56);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 16'd7);
        cycle(1'b0, 1'b0, 1'b0, '0);
        read_range(0, 1);

        // Asynchronous reset mid-capture; later words ignored until set.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, DW'(40 + i));
        async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, DW'(77 + i));
        read_range(0, 5);

        // Randomized frames: random gaps, sets, frame ends and reads,
        // including reads of the address being written in the same cycle.
        for (int f = 0; f < 20; f++) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            for (int c = 0; c < 60; c++) begin
                cycle($urandom_range(0, 59) == 0,
                      $urandom_range(0, 3) != 0,
                      (f % 4 == 3) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 24) == 0),
                      DW'($urandom),
                      $urandom_range(0, 2) == 0,
                      AW'($urandom_range(0, 31)));
            end
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
